// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// the reset PC and the instruction word presented for faulted fetches.
package ifu_fetch_pkg;

   typedef enum logic [1:0] {
      IFU_REQ      = 2'd0,
      IFU_RESP     = 2'd1,
      IFU_HOLD     = 2'd2,
      IFU_WAIT_NPC = 2'd3
   } ifu_state_e;

   localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] IFU_FAULT_INST = 32'h0000_0000;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ifu_fetch_perf_cnt.sv
// Wrapping count of instructions accepted by decode.
module ifu_fetch_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch stage: request one word, latch it,
// present {pc, inst} to decode, then wait for commit to supply the next PC.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [31:0]      mem_req_addr,
   input  logic             mem_resp_valid,
   output logic             mem_resp_ready,
   input  logic [31:0]      mem_resp_data,
   input  logic             mem_resp_err,
   output logic             valid_out_idu,
   input  logic             ready_in_idu,
   output logic [31:0]      pc_out,
   output logic [31:0]      inst_out,
   output logic             fetch_fault,
   input  logic             npc_valid,
   input  logic [31:0]      npc,
   output logic [CNT_W-1:0] fetch_cnt
);

   // Handshake rule on every port: a transfer happens on a rising edge where
   // valid and ready are both high; valid never depends on ready, and all
   // outputs here come from registers only.
   ifu_state_e  state_q;
   ifu_state_e  state_d;
   logic [31:0] pc_r;
   logic        misaligned;
   logic        decode_accept;

   assign misaligned    = pc_misaligned(pc_r);
   assign decode_accept = (state_q == IFU_HOLD) && ready_in_idu;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IFU_REQ: begin
            if (misaligned) begin
               state_d = IFU_HOLD;
            end else if (mem_req_ready) begin
               state_d = IFU_RESP;
            end
         end
         IFU_RESP: begin
            if (mem_resp_valid) begin
               state_d = IFU_HOLD;
            end
         end
         IFU_HOLD: begin
            if (ready_in_idu) begin
               state_d = IFU_WAIT_NPC;
            end
         end
         IFU_WAIT_NPC: begin
            if (npc_valid) begin
               state_d = IFU_REQ;
            end
         end
         default: state_d = IFU_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IFU_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // npc is only consumed in WAIT_NPC; a misaligned value is taken as-is
   // and turned into a fault when REQ sees it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if ((state_q == IFU_WAIT_NPC) && npc_valid) begin
         pc_r <= npc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_out    <= IFU_FAULT_INST;
         fetch_fault <= 1'b0;
      end else if ((state_q == IFU_REQ) && misaligned) begin
         inst_out    <= IFU_FAULT_INST;
         fetch_fault <= 1'b1;
      end else if ((state_q == IFU_RESP) && mem_resp_valid) begin
         inst_out    <= mem_resp_data;
         fetch_fault <= mem_resp_err;
      end
   end

   assign mem_req_valid  = (state_q == IFU_REQ) && !misaligned;
   assign mem_req_addr   = pc_r;
   assign mem_resp_ready = (state_q == IFU_RESP);
   assign valid_out_idu  = (state_q == IFU_HOLD);
   assign pc_out         = pc_r;

   ifu_fetch_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (decode_accept),
      .count (fetch_cnt)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, fetch timing, backpressure, memory
// wait states, next-PC handling, faults and reset while a response is pending.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        valid_out_idu;
   logic        ready_in_idu;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        fetch_fault;
   logic        npc_valid;
   logic [31:0] npc;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;
   int req_hs = 0;

   ifu_fetch #(
      .RESET_PC (32'h8000_0000),
      .CNT_W    (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .valid_out_idu  (valid_out_idu),
      .ready_in_idu   (ready_in_idu),
      .pc_out         (pc_out),
      .inst_out       (inst_out),
      .fetch_fault    (fetch_fault),
      .npc_valid      (npc_valid),
      .npc            (npc),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_data = 32'h0; mem_resp_err = 1'b0; ready_in_idu = 1'b0;
      npc_valid = 1'b0; npc = 32'h0;
      step(); step();
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %b exp 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h exp 80000000", mem_req_addr); end
      checks++; if (valid_out_idu !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out_idu); end
      checks++; if (inst_out !== 32'h0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_inst got %h/%b exp 0/0", inst_out, fetch_fault); end
      checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fetch_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_first_fetch();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093; mem_resp_err = 1'b0;
      checks++; if (mem_resp_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL first_resp_phase got rdy=%b req=%b exp 1/0", mem_resp_ready, mem_req_valid); end
      step();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out_idu !== 1'b1) begin errors++; $display("FAIL first_valid_out got %b exp 1", valid_out_idu); end
      checks++; if (pc_out !== 32'h8000_0000) begin errors++; $display("FAIL first_pc got %h exp 80000000", pc_out); end
      checks++; if (inst_out !== 32'h0010_0093 || fetch_fault !== 1'b0) begin errors++; $display("FAIL first_inst got %h/%b exp 00100093/0", inst_out, fetch_fault); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (valid_out_idu !== 1'b1 || inst_out !== 32'h0010_0093 || pc_out !== 32'h8000_0000 || fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL backpressure_hold cyc %0d got v=%b inst=%h pc=%h cnt=%0d", i, valid_out_idu, inst_out, pc_out, fetch_cnt);
         end
      end
      ready_in_idu = 1'b1;
      step();
      ready_in_idu = 1'b0;
      checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL backpressure_cnt got %0d exp 1", fetch_cnt); end
      checks++; if (valid_out_idu !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL wait_npc_outputs got v=%b req=%b exp 0/0", valid_out_idu, mem_req_valid); end
   endtask

   task automatic test_wait_states();
      int hs_start;
      npc_valid = 1'b1; npc = 32'h8000_0004;
      step();
      npc_valid = 1'b0;
      hs_start = req_hs;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL npc_to_req got v=%b addr=%h exp 1/80000004", mem_req_valid, mem_req_addr); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || mem_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL req_stall cyc %0d got v=%b addr=%h rr=%b", i, mem_req_valid, mem_req_addr, mem_resp_ready);
         end
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_resp_ready !== 1'b1 || valid_out_idu !== 1'b0 || mem_req_addr !== 32'h8000_0004) begin
            errors++;
            $display("FAIL resp_wait cyc %0d got rr=%b v=%b addr=%h", i, mem_resp_ready, valid_out_idu, mem_req_addr);
         end
         step();
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0513; mem_resp_err = 1'b0;
      step();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out_idu !== 1'b1 || inst_out !== 32'h0000_0513 || pc_out !== 32'h8000_0004) begin errors++; $display("FAIL wait_latch got v=%b inst=%h pc=%h exp 1/00000513/80000004", valid_out_idu, inst_out, pc_out); end
      checks++; if (req_hs - hs_start !== 1) begin errors++; $display("FAIL req_handshakes got %0d exp 1", req_hs - hs_start); end
   endtask

   task automatic test_next_pc();
      npc_valid = 1'b1; npc = 32'h8000_0010; ready_in_idu = 1'b1;
      step();
      ready_in_idu = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || fetch_cnt !== 32'd2) begin errors++; $display("FAIL npc_in_hold got req=%b cnt=%0d exp 0/2", mem_req_valid, fetch_cnt); end
      step();
      npc_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL npc_next_req got v=%b addr=%h exp 1/80000010", mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_bus_error();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678; mem_resp_err = 1'b1;
      step();
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      checks++; if (valid_out_idu !== 1'b1 || fetch_fault !== 1'b1 || inst_out !== 32'h1234_5678) begin errors++; $display("FAIL bus_err got v=%b f=%b inst=%h exp 1/1/12345678", valid_out_idu, fetch_fault, inst_out); end
      ready_in_idu = 1'b1;
      step();
      ready_in_idu = 1'b0;
      checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL bus_err_cnt got %0d exp 3", fetch_cnt); end
   endtask

   task automatic test_misaligned();
      int hs_start;
      hs_start = req_hs;
      npc_valid = 1'b1; npc = 32'h8000_0002;
      step();
      npc_valid = 1'b0;
      mem_req_ready = 1'b1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL misalign_no_req got %b exp 0", mem_req_valid); end
      step();
      mem_req_ready = 1'b0;
      checks++; if (valid_out_idu !== 1'b1 || fetch_fault !== 1'b1 || inst_out !== 32'h0 || pc_out !== 32'h8000_0002) begin errors++; $display("FAIL misalign_hold got v=%b f=%b inst=%h pc=%h exp 1/1/0/80000002", valid_out_idu, fetch_fault, inst_out, pc_out); end
      checks++; if (req_hs !== hs_start) begin errors++; $display("FAIL misalign_handshakes got %0d exp 0", req_hs - hs_start); end
      ready_in_idu = 1'b1;
      step();
      ready_in_idu = 1'b0;
      checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL misalign_cnt got %0d exp 4", fetch_cnt); end
   endtask

   task automatic test_reset_in_resp();
      npc_valid = 1'b1; npc = 32'h8000_0020;
      step();
      npc_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL pre_reset_resp got %b exp 1", mem_resp_ready); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (dut.state_q !== IFU_REQ || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_in_resp got st=%0d v=%b addr=%h exp 0/1/80000000", dut.state_q, mem_req_valid, mem_req_addr); end
      checks++; if (fetch_cnt !== 32'd0 || mem_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_in_resp_cnt got cnt=%0d rr=%b exp 0/0", fetch_cnt, mem_resp_ready); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
      step();
      checks++; if (mem_resp_ready !== 1'b0 || valid_out_idu !== 1'b0 || inst_out !== 32'h0) begin errors++; $display("FAIL late_resp got rr=%b v=%b inst=%h exp 0/0/0", mem_resp_ready, valid_out_idu, inst_out); end
      step();
      mem_resp_valid = 1'b0;
      checks++; if (valid_out_idu !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL late_resp_state got v=%b req=%b exp 0/1", valid_out_idu, mem_req_valid); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_wait_states();
      test_next_pc();
      test_bus_error();
      test_misaligned();
      test_reset_in_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
